disp_arbiter: RTL

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_pkg.sv | 28 ++
 rtl/disp_arbiter_rr_pick.sv | 27 ++
 rtl/disp_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-ownership arbiter.
package disp_pkg;

    localparam int N_REQ = 3;
    localparam int CNT_W = 16;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } disp_state_e;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic [N_REQ-1:0] onehot(input idx_t i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Index after i, wrapping modulo N_REQ.
    function automatic idx_t rr_next(input idx_t i);
        return (i == idx_t'(N_REQ - 1)) ? '0 : i + idx_t'(1);
    endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_start.
module rr_pick
    import disp_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  idx_t             i_start,
    output logic             o_valid,
    output idx_t             o_idx
);

    idx_t w_cand;

    // Scan from the farthest candidate back to i_start so the nearest one wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_start;
        w_cand  = i_start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = idx_t'((int'(i_start) + k) % N_REQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Arbitrates three requesters for the display with a minimum hold time in ms ticks.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int          HOLD_MS  = 1000,
    parameter logic [15:0] IDLE_DAT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce1ms,
    input  logic [N_REQ-1:0] req,
    input  logic [15:0]      dat0,
    input  logic [15:0]      dat1,
    input  logic [15:0]      dat2,
    input  logic [3:0]       ptr0,
    input  logic [3:0]       ptr1,
    input  logic [3:0]       ptr2,
    output logic [N_REQ-1:0] gnt,
    output logic [15:0]      dat,
    output logic [3:0]       ptr,
    output logic             busy,
    output disp_state_e      dbg_state
);

    disp_state_e      r_state, w_state_n;
    idx_t             r_owner, w_owner_n;
    idx_t             r_last, w_last_n;
    cnt_t             r_cnt, w_cnt_n;
    logic [N_REQ-1:0] r_gnt;
    logic [15:0]      r_dat, w_dat_n;
    logic [3:0]       r_ptr, w_ptr_n;
    logic             r_busy;

    logic [N_REQ-1:0] w_req_m;
    logic             w_pick_vld;
    idx_t             w_pick_idx;
    logic             w_grant_new;

    // The current owner is masked out, so a valid pick always means a different requester.
    assign w_req_m = req & ~((r_state == OWN) ? onehot(r_owner) : '0);

    rr_pick u_pick (
        .i_req   (w_req_m),
        .i_start (rr_next(r_last)),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_n   = r_state;
        w_owner_n   = r_owner;
        w_last_n    = r_last;
        w_cnt_n     = r_cnt;
        w_grant_new = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_n   = OWN;
                    w_grant_new = 1'b1;
                end
            end
            OWN: begin
                if (!req[r_owner]) begin
                    if (w_pick_vld) w_grant_new = 1'b1;
                    else            w_state_n   = IDLE;
                end else if (r_cnt == '0) begin
                    if (w_pick_vld) w_grant_new = 1'b1;
                end else if (ce1ms) begin
                    w_cnt_n = r_cnt - cnt_t'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
        // A grant change always reloads, swallowing any coincident tick.
        if (w_grant_new) begin
            w_owner_n = w_pick_idx;
            w_last_n  = w_pick_idx;
            w_cnt_n   = cnt_t'(HOLD_MS);
        end
    end

    always_comb begin
        w_dat_n = IDLE_DAT;
        w_ptr_n = '0;
        if (w_state_n == OWN) begin
            case (w_owner_n)
                2'd0:    begin w_dat_n = dat0; w_ptr_n = ptr0; end
                2'd1:    begin w_dat_n = dat1; w_ptr_n = ptr1; end
                default: begin w_dat_n = dat2; w_ptr_n = ptr2; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= idx_t'(N_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_dat   <= IDLE_DAT;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
            r_gnt   <= (w_state_n == OWN) ? onehot(w_owner_n) : '0;
            r_dat   <= w_dat_n;
            r_ptr   <= w_ptr_n;
            r_busy  <= (w_state_n == OWN);
        end
    end

    assign gnt       = r_gnt;
    assign dat       = r_dat;
    assign ptr       = r_ptr;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
